// File: rtl/uart_msg_pkg.sv
// uart_msg_pkg: shared RX state encoding, ASCII constants and hex decoder (UART_MSG_PARITY_EN adds the PARITY state)
package uart_msg_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3
`ifdef UART_MSG_PARITY_EN
        , RX_PARITY = 3'd4
`endif
    } rx_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    // Returns {valid, code}; valid is low for anything outside 0-9, A-F, a-f.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b1, 4'(c - 8'h30)} :
               (c >= 8'h41 && c <= 8'h46) ? {1'b1, 4'(c - 8'h37)} :
               (c >= 8'h61 && c <= 8'h66) ? {1'b1, 4'(c - 8'h57)} : 5'b0;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised UART byte receiver, 8N1 or 8E1 when UART_MSG_PARITY_EN is defined
module uart_rx_byte
    import uart_msg_pkg::*;
#(
    parameter int BAUD_DIV = 521
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       err_frame
);

    localparam int TW = $clog2(BAUD_DIV);

    logic          rx_meta, rx_sync, rx_prev;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    rx_state_t     state;
`ifdef UART_MSG_PARITY_EN
    logic          parity_ok;
`else
    localparam logic parity_ok = 1'b1;
`endif

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame FSM: half-bit to the start centre, then one sample per bit period
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
`ifdef UART_MSG_PARITY_EN
            parity_ok  <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            timer      <= (timer == '0) ? TW'(BAUD_DIV - 1) : timer - TW'(1);
            case (state)
                RX_IDLE: if (rx_prev && !rx_sync) begin
                    state <= RX_START;
                    timer <= TW'(BAUD_DIV / 2 - 1);
                end
                RX_START: if (timer == '0) state <= rx_sync ? RX_IDLE : RX_DATA;
                RX_DATA: if (timer == '0) begin
                    data    <= {rx_sync, data[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_MSG_PARITY_EN
                    if (bit_cnt == 3'd7) state <= RX_PARITY;
`else
                    if (bit_cnt == 3'd7) state <= RX_STOP;
`endif
                end
`ifdef UART_MSG_PARITY_EN
                RX_PARITY: if (timer == '0) begin
                    parity_ok <= ~^{data, rx_sync};
                    state     <= RX_STOP;
                end
`endif
                RX_STOP: if (timer == '0) begin
                    byte_valid <= rx_sync && parity_ok;
                    err_frame  <= !(rx_sync && parity_ok);
                    state      <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_message_loader.sv
// uart_message_loader: UART hex-character message source with atomic commit to the scroller bus
module uart_message_loader
    import uart_msg_pkg::*;
#(
    parameter int                     BAUD_DIV = 521,
    parameter int                     MSG_LEN  = 16,
    parameter logic [4*MSG_LEN-1:0]   INIT_MSG = 64'h0123456789ABCDEF,
    parameter logic [3:0]             PAD_CODE = 4'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [4*MSG_LEN-1:0]   message,
    output logic                   msg_valid,
    output logic                   err_frame,
    output logic                   err_char,
    output logic                   busy
);

    localparam int CW = $clog2(MSG_LEN + 1);

    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic [4:0]           dec;
    logic [CW-1:0]        count, count_next;
    logic [4*MSG_LEN-1:0] shadow, written, padded;
    logic                 hex_ok, full, early, esc, bad;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (byte_data),
        .byte_valid (byte_valid),
        .err_frame  (err_frame)
    );

    // Classify the received byte and form the two candidate commit images
    always_comb begin
        dec     = hex_decode(byte_data);
        written = shadow;
        padded  = shadow;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (i == MSG_LEN - 1 - int'(count)) written[4*i +: 4] = dec[3:0];
            if (i < MSG_LEN - int'(count)) padded[4*i +: 4] = PAD_CODE;
        end
        hex_ok     = byte_valid && dec[4];
        full       = hex_ok && int'(count) == MSG_LEN - 1;
        early      = byte_valid && byte_data == ASCII_CR && count != '0;
        esc        = byte_valid && byte_data == ASCII_ESC;
        bad        = byte_valid && !dec[4] && byte_data != ASCII_CR && byte_data != ASCII_ESC;
        count_next = (full || early || esc) ? '0 : hex_ok ? count + CW'(1) : count;
    end

    // Shadow fill, counter and atomic commit of the whole message
    always_ff @(posedge clk) begin
        if (reset) begin
            message   <= INIT_MSG;
            msg_valid <= 1'b0;
            err_char  <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            shadow    <= '0;
        end else begin
            shadow    <= hex_ok ? written : shadow;
            message   <= full ? written : early ? padded : message;
            msg_valid <= full || early;
            err_char  <= bad;
            count     <= count_next;
            busy      <= count_next != '0;
        end
    end

endmodule

// File: tb/tb_uart_message_loader.sv
// tb_uart_message_loader: randomized self-checking bench against a character-level message model
module tb_uart_message_loader;

    localparam int          BAUD_DIV = 8;
    localparam logic [63:0] INIT     = 64'h0123456789ABCDEF;
    localparam logic [3:0]  PAD      = 4'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [63:0] message;
    logic        msg_valid, err_frame, err_char, busy;

    int n_checks = 0, n_errors = 0;
    int n_valid = 0, n_ferr = 0, n_cerr = 0, n_bad_change = 0;
    logic [63:0] last_msg;

    int          m_count;
    logic [3:0]  m_shadow [16];
    logic [63:0] m_msg;
    int          m_valid = 0, m_ferr = 0, m_cerr = 0;

    uart_message_loader #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .message   (message),
        .msg_valid (msg_valid),
        .err_frame (err_frame),
        .err_char  (err_char),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (msg_valid) n_valid++;
            if (err_frame) n_ferr++;
            if (err_char) n_cerr++;
            if (message !== last_msg && !msg_valid) n_bad_change++;
        end
        last_msg = message;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int hex_val(input logic [7:0] b);
        string up = "0123456789ABCDEF";
        string lo = "0123456789abcdef";
        for (int i = 0; i < 16; i++)
            if (b == up[i] || b == lo[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] model_image();
        logic [63:0] m = '0;
        for (int p = 0; p < 16; p++) m[63-4*p -: 4] = (p < m_count) ? m_shadow[p] : PAD;
        return m;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_msg   = INIT;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int v = hex_val(b);
        if (v >= 0) begin
            m_shadow[m_count] = 4'(v);
            m_count++;
            if (m_count == 16) begin
                m_msg = model_image();
                m_valid++;
                m_count = 0;
            end
        end else if (b == 8'h0D) begin
            if (m_count > 0) begin
                m_msg = model_image();
                m_valid++;
                m_count = 0;
            end
        end else if (b == 8'h1B) m_count = 0;
        else m_cerr++;
    endtask

    task automatic check_state();
        check("message", message, m_msg);
        check("busy", 64'(busy), 64'(m_count != 0));
        check("msg_valid_pulses", 64'(n_valid), 64'(m_valid));
        check("err_frame_pulses", 64'(n_ferr), 64'(m_ferr));
        check("err_char_pulses", 64'(n_cerr), 64'(m_cerr));
    endtask

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BAUD_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_MSG_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_ok);
        if (stop_ok) model_byte(b);
        else m_ferr++;
        rx = 1'b1;
        if (!stop_ok && gap < 1) gap = 1;
        if (gap > 0) begin
            idle(gap * BAUD_DIV);
            check_state();
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, (i == s.len() - 1) ? 2 : gap);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        rx = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check("reset_message", message, INIT);
        check("reset_busy", 64'(busy), 64'd0);
        model_reset();
        reset = 1'b0;
        idle(2 * BAUD_DIV);
    endtask

    initial begin
        string hexchars = "0123456789ABCDEFabcdef";
        logic [7:0] b;
        int sel;
        model_reset();
        do_reset(5);
        check("reset_msg_valid", 64'(msg_valid), 64'd0);
        check("reset_err_frame", 64'(err_frame), 64'd0);
        check("reset_err_char", 64'(err_char), 64'd0);
        check_state();

        send_byte("F", 1'b1, 1);
        check("busy_after_first", 64'(busy), 64'd1);
        send_str("EDCBA9876543210", 0);
        check("full_message", message, 64'hFEDCBA9876543210);

        send_str("a5", 1);
        send_byte(8'h0D, 1'b1, 2);
        check("early_commit", message, 64'hA500000000000000);
        send_byte(8'h0D, 1'b1, 2);

        send_str("12", 1);
        send_byte("Z", 1'b1, 1);
        send_byte(8'h1B, 1'b1, 2);
        send_str("7777777777777777", 0);
        check("after_esc", message, 64'h7777777777777777);

        send_byte("4", 1'b1, 1);
        send_byte(8'h33, 1'b0, 2);
        send_byte(8'h0D, 1'b1, 2);

        send_str("98765", 1);
        do_reset(4);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        do_reset(3);
        send_str("0f1e2d3c4b5a6978", 0);
        check("post_reset_commit", message, 64'h0F1E2D3C4B5A6978);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8) b = hexchars[$urandom_range(0, 21)];
            else if (sel == 8) b = 8'h0D;
            else if (sel == 9) b = ($urandom_range(0, 3) == 0) ? 8'h1B : 8'h30;
            else b = 8'($urandom_range(0, 255));
            send_byte(b, $urandom_range(0, 19) != 0, $urandom_range(0, 2));
        end
        idle(3 * BAUD_DIV);
        check_state();
        check("no_partial_update", 64'(n_bad_change), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
